// File: rtl/sr_cmd_pkg.sv
// Shared types and defaults for the set/reset command generator.
// Holds the FSM state encoding and the default parameter values.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SET_P,
    CLR_P,
    HOLD
  } state_e;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int HOLDOFF_DEF    = 2;
  localparam int CNT_W_DEF      = 8;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, saturating debounce counter and rise detect.
// o_rise is a registered one-cycle pulse on a debounced 0->1 change.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             w_diff;
  logic             w_done;

  assign w_diff = r_sync[1] ^ r_level;
  assign w_done = w_diff && (r_cnt == LAST);

  // sync, count stable differing cycles, flip level when count is met
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_rise <= w_done && !r_level;
      if (w_done) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear command generator for an SR flip-flop.
// Optional toggle request enabled by SR_CMD_GEN_TOGGLE_EN.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int HOLDOFF    = HOLDOFF_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit PRIO_SET   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
`ifdef SR_CMD_GEN_TOGGLE_EN
  input  logic tgl_req,
`endif
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic q_est
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  if ((DEB_CYCLES < 1) || (DEB_CYCLES > (2**CNT_W) - 1)) begin : g_bad_deb
    $error("sr_cmd_gen: DEB_CYCLES out of range");
  end

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_set_pend;
  logic             r_clr_pend;
  logic             r_conflict;
  logic             r_q;
  logic             w_set_rise;
  logic             w_clr_rise;
  logic             w_set_lvl;
  logic             w_clr_lvl;
  logic             w_svc;
  logic             w_conf;
  logic             w_unused;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_set (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_raw   (set_req),
    .o_level (w_set_lvl),
    .o_rise  (w_set_rise)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_raw   (clr_req),
    .o_level (w_clr_lvl),
    .o_rise  (w_clr_rise)
  );

`ifdef SR_CMD_GEN_TOGGLE_EN
  logic r_tgl_pend;
  logic w_tgl_rise;
  logic w_tgl_lvl;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_tgl (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_raw   (tgl_req),
    .o_level (w_tgl_lvl),
    .o_rise  (w_tgl_rise)
  );

  assign w_unused = w_set_lvl ^ w_clr_lvl ^ w_tgl_lvl;

  // toggle pending flag; a new event beats a same-edge service clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tgl_pend <= 1'b0;
    else      r_tgl_pend <= w_tgl_rise | (r_tgl_pend & ~w_svc);
  end
`else
  assign w_unused = w_set_lvl ^ w_clr_lvl;
`endif

  // next-state: priority pick in IDLE, fixed pulse/hold sequence after
  always_comb begin
    w_next = r_state;
    w_conf = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_set_pend && r_clr_pend) begin
          w_conf = 1'b1;
          w_next = PRIO_SET ? SET_P : CLR_P;
        end else if (r_set_pend) begin
          w_next = SET_P;
        end else if (r_clr_pend) begin
          w_next = CLR_P;
        end
`ifdef SR_CMD_GEN_TOGGLE_EN
        else if (r_tgl_pend) begin
          w_next = r_q ? CLR_P : SET_P;
        end
        if (r_tgl_pend && (r_set_pend || r_clr_pend)) w_conf = 1'b1;
`endif
      end
      SET_P, CLR_P: w_next = (HOLDOFF > 0) ? HOLD : IDLE;
      HOLD: if (r_hcnt == HOLD_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // leaving IDLE consumes every pending flag, winners and losers alike
  assign w_svc = (r_state == IDLE) && (w_next != IDLE);

  // state, hold counter, pending flags, conflict pulse and shadow q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hcnt     <= '0;
      r_set_pend <= 1'b0;
      r_clr_pend <= 1'b0;
      r_conflict <= 1'b0;
      r_q        <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_set_pend <= w_set_rise | (r_set_pend & ~w_svc);
      r_clr_pend <= w_clr_rise | (r_clr_pend & ~w_svc);
      r_conflict <= w_conf;
      if (r_state == SET_P) r_q <= 1'b1;
      if (r_state == CLR_P) r_q <= 1'b0;
      if (r_state != HOLD) r_hcnt <= '0;
      else if (r_hcnt != '1) r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  assign s        = (r_state == SET_P);
  assign r        = (r_state == CLR_P);
  assign busy     = (r_state != IDLE);
  assign conflict = r_conflict;
  assign q_est    = r_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: cycle table plus hand sequences.
// Toggle checks compile in when SR_CMD_GEN_TOGGLE_EN is defined.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst;
  logic set_req;
  logic clr_req;
  logic tgl_req;
  logic s_a, r_a, busy_a, conf_a, q_a;
  logic s_b, r_b, busy_b, conf_b, q_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sr_cmd_gen #(.PRIO_SET(1'b0)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
`ifdef SR_CMD_GEN_TOGGLE_EN
    .tgl_req  (tgl_req),
`endif
    .s        (s_a),
    .r        (r_a),
    .busy     (busy_a),
    .conflict (conf_a),
    .q_est    (q_a)
  );

  sr_cmd_gen #(.PRIO_SET(1'b1)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
`ifdef SR_CMD_GEN_TOGGLE_EN
    .tgl_req  (tgl_req),
`endif
    .s        (s_b),
    .r        (r_b),
    .busy     (busy_b),
    .conflict (conf_b),
    .q_est    (q_b)
  );

`ifndef SR_CMD_GEN_TOGGLE_EN
  logic unused_tgl;
  assign unused_tgl = tgl_req;
`endif

  typedef struct {
    logic set, clr;
    logic s, r, sb, rb, busy, conf, q;
  } vec_t;

  vec_t vecs[98];

  function automatic logic in_r(int t, int lo, int hi);
    return (t >= lo) && (t <= hi);
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic b, input logic t);
    set_req = a;
    clr_req = b;
    tgl_req = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".s"}, s_a, 1'b0);
    chk({nm, ".r"}, r_a, 1'b0);
    chk({nm, ".busy"}, busy_a, 1'b0);
    chk({nm, ".conf"}, conf_a, 1'b0);
    chk({nm, ".q"}, q_a, 1'b0);
    chk({nm, ".sb"}, s_b, 1'b0);
    chk({nm, ".qb"}, q_b, 1'b0);
  endtask

`ifdef SR_CMD_GEN_TOGGLE_EN
  task automatic win(input logic a, input logic b, input logic t,
                     input logic es, input logic er, input logic ec,
                     input logic eq, input string nm);
    for (int k = 0; k < 20; k++) begin
      step((k < 6) ? a : 1'b0, (k < 6) ? b : 1'b0, (k < 6) ? t : 1'b0);
      chk($sformatf("%s.s@%0d", nm, k), s_a, es && (k == 7));
      chk($sformatf("%s.r@%0d", nm, k), r_a, er && (k == 7));
      chk($sformatf("%s.conf@%0d", nm, k), conf_a, ec && (k == 7));
      chk($sformatf("%s.busy@%0d", nm, k), busy_a, in_r(k, 7, 9));
    end
    chk({nm, ".q"}, q_a, eq);
  endtask
`endif

  initial begin
    for (int t = 0; t < 98; t++) begin
      vecs[t].set  = in_r(t, 0, 11) | in_r(t, 20, 22) | in_r(t, 32, 43) |
                     in_r(t, 56, 75) | (t >= 88);
      vecs[t].clr  = in_r(t, 32, 43) | in_r(t, 59, 75) | (t >= 91);
      vecs[t].s    = (t == 7) | (t == 63) | (t == 95);
      vecs[t].r    = (t == 39) | (t == 67);
      vecs[t].sb   = (t == 7) | (t == 39) | (t == 63) | (t == 95);
      vecs[t].rb   = (t == 67);
      vecs[t].busy = in_r(t, 7, 9) | in_r(t, 39, 41) | in_r(t, 63, 65) |
                     in_r(t, 67, 69) | in_r(t, 95, 97);
      vecs[t].conf = (t == 39);
      vecs[t].q    = in_r(t, 8, 39) | in_r(t, 64, 67) | (t >= 96);
    end

    rst = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    tgl_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 98; t++) begin
      step(vecs[t].set, vecs[t].clr, 1'b0);
      chk($sformatf("s@%0d", t), s_a, vecs[t].s);
      chk($sformatf("r@%0d", t), r_a, vecs[t].r);
      chk($sformatf("s_b@%0d", t), s_b, vecs[t].sb);
      chk($sformatf("r_b@%0d", t), r_b, vecs[t].rb);
      chk($sformatf("busy@%0d", t), busy_a, vecs[t].busy);
      chk($sformatf("busy_b@%0d", t), busy_b, vecs[t].busy);
      chk($sformatf("conf@%0d", t), conf_a, vecs[t].conf);
      chk($sformatf("conf_b@%0d", t), conf_b, vecs[t].conf);
      chk($sformatf("q@%0d", t), q_a, vecs[t].q);
      chk($sformatf("excl@%0d", t), s_a & r_a, 1'b0);
    end

    rst = 1'b0;
    set_req = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;

    for (int u = 0; u < 10; u++) begin
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("post_rst.r@%0d", u), r_a, u == 7);
      chk($sformatf("post_rst.s@%0d", u), s_a, 1'b0);
      chk($sformatf("post_rst.busy@%0d", u), busy_a, in_r(u, 7, 9));
      chk($sformatf("post_rst.q@%0d", u), q_a, 1'b0);
    end

    for (int u = 0; u < 12; u++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("fall.r@%0d", u), r_a, 1'b0);
      chk($sformatf("fall.s@%0d", u), s_a, 1'b0);
    end

`ifdef SR_CMD_GEN_TOGGLE_EN
    win(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "tgl1");
    win(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "tgl2");
    win(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "tgl_set");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the set/reset flip-flop.
- Takes raw, possibly bouncy set and clear request lines and synchronizes and debounces each one.
- Turns each debounced rising edge into a single-cycle s or r pulse, with enforced hold-off spacing between pulses.
- Guarantees s and r are never high together, so the flip-flop's undefined s=r=1 input combination can never be produced.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronized cycles needed before the debounced level changes; legal range 1 to 2^CNT_W-1.
- HOLDOFF, 2: idle cycles forced after every issued pulse; 0 means no hold state.
- CNT_W, 8: width of the debounce and hold-off counters.
- PRIO_SET, 0: 1 means set wins a simultaneous conflict; 0 means clear wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- set_req  input  1  raw asynchronous set request; level, active high.
- clr_req  input  1  raw asynchronous clear request; level, active high.
- s  output  1  registered one-cycle set pulse to the flip-flop.
- r  output  1  registered one-cycle reset pulse to the flip-flop.
- busy  output  1  high whenever the FSM is not in IDLE.
- conflict  output  1  one-cycle pulse when a pending request is discarded by priority.
- q_est  output  1  shadow of the flip-flop state: the last command issued.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst).
  - While rst=0: s, r, busy, conflict and q_est are 0.
  - Synchronizers, debounced levels, counters and pending flags are all cleared; FSM is in IDLE.
  - Reset asserted mid-pulse or mid-hold aborts immediately, and any pending request is lost.
- Input path, per request line:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced value differs from the debounced level and clears when they match. When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - A debounced 0→1 transition sets the pending flag (set_pend or clr_pend).
  - A new event on an already-pending line merges with it: no second pulse.
  - A debounced falling edge produces no event.
- Latency from IDLE: raw rises just before edge 0 and stays high → s (or r) is high for exactly one cycle, starting on edge 2+DEB_CYCLES+1. With defaults, s is high on edge 7.
- FSM states: IDLE, SET_P, CLR_P, HOLD.
  - IDLE, both pending: service the PRIO_SET winner, clear both flags, pulse conflict=1 for that cycle.
  - IDLE, only set_pend: go to SET_P and clear set_pend.
  - IDLE, only clr_pend: go to CLR_P and clear clr_pend.
  - SET_P: s=1 and q_est←1. Next state is HOLD if HOLDOFF>0, else IDLE.
  - CLR_P: r=1 and q_est←0. Same exit rule as SET_P.
  - HOLD: s=r=0 for exactly HOLDOFF cycles, then IDLE.
  - New events arriving during SET_P, CLR_P or HOLD are latched as pending and are evaluated on return to IDLE.
- Invariants:
  - s and r are never both 1.
  - s and r are never high on consecutive cycles; minimum spacing between pulses is HOLDOFF+1 idle cycles.
  - busy=1 in SET_P, CLR_P and HOLD.
- Simultaneous pend set and FSM clear on the same edge: the new event wins and the flag stays set.
- Counters saturate, never wrap. A DEB_CYCLES value outside the legal range is a parameter error.

Optional Feature:
- Macro: SR_CMD_GEN_TOGGLE_EN.
- Defined:
  - Adds input tgl_req (1 bit, raw), with the same synchronize/debounce/pending path as the other requests.
  - In IDLE, a pending toggle becomes SET_P if q_est=0, otherwise CLR_P.
  - Toggle has the lowest priority. If set or clear is also pending, the toggle is discarded and conflict is pulsed.
- Undefined: no tgl_req port, no toggle logic; behaviour is otherwise identical.

Decomposition:
- Package sr_cmd_pkg holds:
  - the state enum (IDLE, SET_P, CLR_P, HOLD);
  - default constants DEB_CYCLES_DEF=4, HOLDOFF_DEF=2 and CNT_W_DEF=8.
- Sub-module sr_debounce (sync + debounce counter + rising-edge detect, parameterized by DEB_CYCLES and CNT_W):
  - instantiated once per request line;
  - outputs a level and a one-cycle rise event.

Test Plan:
- Reset then set_req held high from edge 0 (defaults) → s=1 only on edge 7, q_est=1 from edge 8, busy on edges 7–9, r stays 0.
- set_req glitch high for 3 cycles then low (DEB_CYCLES=4) → no s pulse and no pending flag.
- set_req and clr_req rise on the same edge with PRIO_SET=0 → single r pulse with conflict=1 in that cycle, no s pulse; repeat with PRIO_SET=1 → single s pulse.
- clr_req event arrives during HOLD after a set pulse → r pulses on the first IDLE cycle after the 2 hold cycles, never adjacent to s.
- rst driven low during HOLD with clr_req pending → all outputs 0 immediately; after release no r pulse until clr_req is re-debounced from low to high.
- With SR_CMD_GEN_TOGGLE_EN, q_est=0 and tgl_req pulsed → s pulse; second tgl_req → r pulse; tgl_req together with set_req → s pulse and conflict=1.
